// File: rtl/net_bus_tx_fanout.sv
// net_bus_tx_fanout
//   Registered 1-to-CHANNELS broadcast of one NetBus word. A per-channel pending
//   mask tracks which enabled channels still owe the current word, so a slow
//   channel only stalls the upstream and served channels are never re-sent.
//   Optional stall timeout: define NETBUS_TX_TIMEOUT_EN to enable it. Without it,
//   TOUT and TOUT_MSK are tied to zero.
module net_bus_tx_fanout #(
  parameter int DATA_WIDTH     = 4,
  parameter int CHANNELS       = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  CLK,
  input  logic                                  RSTN,
  input  logic [DATA_WIDTH*9+14-1:0]            DATA,
  input  logic                                  VALID,
  output logic                                  READY,
  input  logic [CHANNELS-1:0]                   CH_EN,
  output logic [CHANNELS-1:0]                   WCLK,
  output logic [CHANNELS*(DATA_WIDTH*9+14)-1:0] WDATA,
  output logic [CHANNELS-1:0]                   WVALID,
  input  logic [CHANNELS-1:0]                   WREADY,
  output logic [15:0]                           WORD_CNT,
  output logic                                  TOUT,
  output logic [CHANNELS-1:0]                   TOUT_MSK
);

  localparam int W = DATA_WIDTH*9+14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Parameter range guard: an out-of-range configuration elaborates this empty block.
  if ((CHANNELS < 1) || (CHANNELS > 16) || (TIMEOUT_CYCLES < 2)) begin : g_param_out_of_range
  end

  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [W-1:0]        hold_q, hold_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [CHANNELS-1:0] pend_left_s;
  state_e              state_s;
  logic                ready_s;
  logic                accept_s;

  // The FSM state is fully described by the pending mask: IDLE when nothing is owed.
  assign state_s     = (pending_q == {CHANNELS{1'b0}}) ? ST_IDLE : ST_BUSY;
  // Channels still owing the word after this cycle's handshakes.
  assign pend_left_s = pending_q & ~WREADY;
  // Ready when idle or when every pending channel completes this cycle.
  assign ready_s     = RSTN & ((state_s == ST_IDLE) | (pend_left_s == {CHANNELS{1'b0}}));
  assign accept_s    = VALID & ready_s;

`ifdef NETBUS_TX_TIMEOUT_EN
  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                tout_q, tout_d;
  logic [CHANNELS-1:0] tout_msk_q, tout_msk_d;
  logic                expire_s;

  // Abort only when the stall limit is reached and some channel still will not finish.
  assign expire_s = (state_s == ST_BUSY) & (timer_q == TMR_LAST) &
                    (pend_left_s != {CHANNELS{1'b0}});
`endif

  // Next-state logic: accept loads a fresh mask, otherwise clear completed channels.
  always_comb begin
    pending_d  = pend_left_s;
    hold_d     = hold_q;
    word_cnt_d = word_cnt_q;
`ifdef NETBUS_TX_TIMEOUT_EN
    timer_d    = timer_q;
    tout_d     = 1'b0;
    tout_msk_d = tout_msk_q;
`endif
    if (accept_s) begin
      // A new mask overrides any clears that belonged to the old word.
      pending_d  = CH_EN;
      hold_d     = DATA;
      word_cnt_d = word_cnt_q + 16'd1;
`ifdef NETBUS_TX_TIMEOUT_EN
      timer_d    = {TMR_W{1'b0}};
`endif
    end
`ifdef NETBUS_TX_TIMEOUT_EN
    else if (expire_s) begin
      pending_d  = {CHANNELS{1'b0}};
      tout_d     = 1'b1;
      tout_msk_d = pend_left_s;
      timer_d    = {TMR_W{1'b0}};
    end else if (state_s == ST_BUSY) begin
      timer_d    = timer_q + TMR_W'(1'b1);
    end else begin
      timer_d    = {TMR_W{1'b0}};
    end
`else
    else begin
      pending_d  = pend_left_s;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pending_q  <= {CHANNELS{1'b0}};
      hold_q     <= {W{1'b0}};
      word_cnt_q <= 16'd0;
`ifdef NETBUS_TX_TIMEOUT_EN
      timer_q    <= {TMR_W{1'b0}};
      tout_q     <= 1'b0;
      tout_msk_q <= {CHANNELS{1'b0}};
`endif
    end else begin
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      word_cnt_q <= word_cnt_d;
`ifdef NETBUS_TX_TIMEOUT_EN
      timer_q    <= timer_d;
      tout_q     <= tout_d;
      tout_msk_q <= tout_msk_d;
`endif
    end
  end

  assign READY    = ready_s;
  assign WCLK     = {CHANNELS{CLK}};
  assign WDATA    = {CHANNELS{hold_q}};
  assign WVALID   = pending_q;
  assign WORD_CNT = word_cnt_q;
`ifdef NETBUS_TX_TIMEOUT_EN
  assign TOUT     = tout_q;
  assign TOUT_MSK = tout_msk_q;
`else
  assign TOUT     = 1'b0;
  assign TOUT_MSK = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_net_bus_tx_fanout.sv
// tb_net_bus_tx_fanout
//   Scoreboard bench: every accepted word is pushed into one expected-word queue
//   per enabled channel; a monitor on the falling edge checks WVALID/WDATA against
//   the queue heads, pops on handshakes, and checks READY, WORD_CNT and TOUT.
module tb_net_bus_tx_fanout;
  localparam int DW = 4;
  localparam int CH = 5;
  localparam int TO = 16;
  localparam int W  = DW*9+14;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic [W-1:0]    DATA;
  logic            VALID;
  logic            READY;
  logic [CH-1:0]   CH_EN;
  logic [CH-1:0]   WCLK;
  logic [CH*W-1:0] WDATA;
  logic [CH-1:0]   WVALID;
  logic [CH-1:0]   WREADY;
  logic [15:0]     WORD_CNT;
  logic            TOUT;
  logic [CH-1:0]   TOUT_MSK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0]  exp_q [CH][$];
  logic [15:0]   cnt_m = 16'd0;
  bit            model_ready = 1'b0;
  bit            tout_fire = 1'b0;
  logic [CH-1:0] tout_fire_msk = '0;
  bit            exp_tout = 1'b0;
  logic [CH-1:0] exp_msk = '0;
  int            busy_k = 0;

  net_bus_tx_fanout #(.DATA_WIDTH(DW), .CHANNELS(CH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .DATA(DATA), .VALID(VALID), .READY(READY),
    .CH_EN(CH_EN), .WCLK(WCLK), .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .WORD_CNT(WORD_CNT), .TOUT(TOUT), .TOUT_MSK(TOUT_MSK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the clock edge: reset, timeout abort, or accept of a new word.
  always @(posedge CLK) begin
    if (!RSTN) begin
      for (int c = 0; c < CH; c++) exp_q[c].delete();
      cnt_m    = 16'd0;
      exp_tout = 1'b0;
      exp_msk  = '0;
      busy_k   = 0;
    end else begin
      exp_tout = 1'b0;
      if (tout_fire) begin
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        exp_tout = 1'b1;
        exp_msk  = tout_fire_msk;
        busy_k   = 0;
      end else if (VALID && model_ready) begin
        cnt_m  = cnt_m + 16'd1;
        busy_k = 0;
        for (int c = 0; c < CH; c++)
          if (CH_EN[c]) exp_q[c].push_back(DATA);
      end
    end
  end

  // Monitor between edges: compare outputs against the model and pop delivered words.
  always @(negedge CLK) begin
    logic [CH-1:0] left_v;
    bit any_v;
    bit ev;
    any_v  = 1'b0;
    left_v = '0;
    chk("wclk", {59'd0, WCLK}, {59'd0, {CH{CLK}}});
    for (int c = 0; c < CH; c++) begin
      ev = (exp_q[c].size() != 0);
      chk($sformatf("wvalid%0d", c), {63'd0, WVALID[c]}, {63'd0, ev});
      if (ev) begin
        any_v = 1'b1;
        chk($sformatf("wdata%0d", c), {14'd0, WDATA[c*W +: W]}, {14'd0, exp_q[c][0]});
        if (WVALID[c] && WREADY[c]) void'(exp_q[c].pop_front());
        if (exp_q[c].size() != 0) left_v[c] = 1'b1;
      end
    end
    if (any_v) busy_k++;
    else busy_k = 0;
    model_ready = RSTN && (left_v == '0);
    chk("ready", {63'd0, READY}, {63'd0, model_ready});
    chk("word_cnt", {48'd0, WORD_CNT}, {48'd0, cnt_m});
    chk("tout", {63'd0, TOUT}, {63'd0, exp_tout});
    chk("tout_msk", {59'd0, TOUT_MSK}, {59'd0, exp_msk});
    tout_fire = 1'b0;
`ifdef NETBUS_TX_TIMEOUT_EN
    if (RSTN && (busy_k == TO) && (left_v != '0)) begin
      tout_fire     = 1'b1;
      tout_fire_msk = left_v;
    end
`endif
  end

  task automatic cyc(input bit v, input logic [W-1:0] d, input logic [CH-1:0] en,
                     input logic [CH-1:0] wr);
    VALID  = v;
    DATA   = d;
    CH_EN  = en;
    WREADY = wr;
    @(posedge CLK);
    #1;
  endtask

  // Stimulus: directed scenarios, randomized traffic, then counter wrap.
  initial begin
    logic [63:0]   r64;
    logic [31:0]   r32;
    logic [CH-1:0] wr;
    int            n;

    // Reset held with VALID=1
    RSTN = 1'b0;
    repeat (3) cyc(1'b1, 50'h3, 5'h1F, 5'h1F);
    RSTN = 1'b1;

    // Eight back-to-back broadcast words
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(i), 5'h1F, 5'h1F);
    chk("cnt_after8", {48'd0, WORD_CNT}, 64'd8);
    repeat (2) cyc(1'b0, 50'h0, 5'h00, 5'h1F);

    // Channel 2 stalls 3 cycles; next word accepted as it completes
    cyc(1'b1, 50'hA5, 5'h1F, 5'h1F);
    repeat (3) cyc(1'b1, 50'hB6, 5'h1F, 5'h1B);
    cyc(1'b1, 50'hB6, 5'h1F, 5'h1F);
    repeat (2) cyc(1'b0, 50'h0, 5'h00, 5'h1F);

    // Partial mask and empty mask
    cyc(1'b1, 50'hC7, 5'h0A, 5'h00);
    cyc(1'b0, 50'h0, 5'h00, 5'h1F);
    cyc(1'b1, 50'hD8, 5'h00, 5'h1F);
    repeat (2) cyc(1'b0, 50'h0, 5'h00, 5'h1F);

    // Channel 4 never ready
    cyc(1'b1, 50'hE9, 5'h1F, 5'h1F);
    repeat (40) cyc(1'b1, 50'hF0, 5'h1F, 5'h0F);
`ifndef NETBUS_TX_TIMEOUT_EN
    chk("stall_ready", {63'd0, READY}, 64'd0);
    chk("stall_tout", {63'd0, TOUT}, 64'd0);
`endif
    repeat (3) cyc(1'b0, 50'h0, 5'h00, 5'h1F);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      RSTN = ($urandom_range(0, 199) != 0);
      r64  = {$urandom, $urandom};
      r32  = $urandom;
      for (int c = 0; c < CH; c++) wr[c] = ($urandom_range(0, 9) < 8);
      cyc(($urandom_range(0, 3) != 0), r64[W-1:0], r32[CH-1:0], wr);
    end
    RSTN = 1'b1;
    repeat (3) cyc(1'b0, 50'h0, 5'h00, 5'h1F);

    // Drive the word counter through its wrap
    n = 65536 - int'(cnt_m);
    for (int i = 0; i < n; i++) cyc(1'b1, W'(i), 5'h00, 5'h1F);
    chk("wrap_cnt", {48'd0, WORD_CNT}, 64'd0);
    repeat (2) cyc(1'b0, 50'h0, 5'h00, 5'h1F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
